zx_flash_port: RTL and testbench
================================

# zx_flash_port

ZX-bus I/O responder for the NeoGS flash programmer: it decodes host IN/OUT cycles to a small bank of ports and turns them into timed read/write cycles on the flash ROM. It sits between the ZX-bus pins (`zxa`, `zxid`, `zxiorq_n`, `zxrd_n`, `zxwr_n`) and the memory-control pins (`romcs_n`, `memoe_n`, `memwe_n`, memory address and data). The ZX host is the initiator; this block is the responder. It runs in the `clk` (24 MHz) domain, with the ZX strobes synchronised internally.

## Interface
- `PORT_BASE`, 8'hB0: ports occupy `zxa[7:0]` = BASE+0..BASE+4.
- `WE_CYC`, 3: width of the `memwe_n` low pulse, in clk cycles (≥1).
- `RD_CYC`, 4: width of the `memoe_n` low pulse, in clk cycles (≥1).

Ports:
- `clk` in 1: working clock.
- `warmres_n` in 1: reset, synchronous, active-low.
- `zxa` in 8: ZX address low byte.
- `zxiorq_n`, `zxrd_n`, `zxwr_n` in 1: ZX strobes, asynchronous.
- `zxid_in` in 8: ZX data from the bus.
- `zxid_out` out 8: data to the ZX bus.
- `zxid_oe` out 1: drive `zxid`.
- `zxblkiorq_n` out 1: low while a decoded port is addressed with `zxiorq_n` low.
- `zxbusin` out 1: 1 = ZX→card, 0 = card→ZX.
- `zxbusena_n` out 1: buffer enable, low while a decoded port is addressed with `zxiorq_n` low.
- `mem_a` out 19: flash address.
- `mem_dout` out 8: flash write data.
- `mem_doe` out 1: drive the memory data bus.
- `mem_din` in 8: flash read data.
- `romcs_n`, `memoe_n`, `memwe_n` out 1: flash controls.
- `busy` out 1: flash cycle in progress.

## Operation
- **Port map (offset from `PORT_BASE`):**
  - 0: ADDR0, `addr[7:0]`, R/W.
  - 1: ADDR1, `addr[15:8]`, R/W.
  - 2: ADDR2, `addr[18:16]` in bits 2:0; reads return 0 in bits 7:3.
  - 3: DATA.
  - 4: STATUS, read-only: bit0 = busy, bit1 = ovf, others 0.
- **Decode is combinational** from the raw pins: `sel = (zxa in range) & ~zxiorq_n`.
  - `zxblkiorq_n = zxbusena_n = ~sel`.
  - `zxbusin = ~(sel & ~zxrd_n)`.
  - `zxid_oe = sel & ~zxrd_n`.
  - `zxid_out` is a mux of registers, combinational on `zxa`.
- **Strobe sync:** `wr_s` and `rd_s` are `~zxiorq_n & ~zx{wr,rd}_n & sel`, each passed through a 2-FF synchroniser.
- **Write event:** rising edge of synced `wr_s`. In that cycle, capture `zxa[2:0]` and `zxid_in`, then act on the captured values.
- **Read-end event:** falling edge of synced `rd_s`, i.e. the end of the IN cycle.
- **DATA write:**
  - If idle: `wdat <= zxid_in`, start a WRITE cycle at `addr`, and `addr <= addr+1` when the cycle completes.
  - If busy: ignore the write and set `ovf`.
- **DATA read:**
  - Returns `rlatch`.
  - At read-end: if idle, start a READ cycle at `addr` (prefetch); on completion `rlatch <= mem_din` and `addr <= addr+1`. If busy, set `ovf`.
- **STATUS read:** read-end clears `ovf`. If `ovf` is set again in the same cycle, set wins.
- **Address wrap:** `addr` is 19 bits and wraps 7FFFF→00000.
- **ADDR writes while busy:** ignored and set `ovf`, so `mem_a` stays stable throughout a cycle.
- **FSM states:** IDLE, W_SETUP, W_PULSE, W_HOLD, R_PULSE, R_DONE.
  - IDLE→W_SETUP (1 clk): `romcs_n`=0, `mem_doe`=1.
  - W_SETUP→W_PULSE: `memwe_n`=0 for WE_CYC clks.
  - W_PULSE→W_HOLD (1 clk): `memwe_n`=1, cs and doe still asserted.
  - W_HOLD→IDLE: deassert all, increment `addr`.
  - IDLE→R_PULSE: `romcs_n`=0, `memoe_n`=0 for RD_CYC clks. Sample `mem_din` on the last of those clks.
  - R_PULSE→R_DONE (1 clk): deassert, update `rlatch`, increment `addr`, →IDLE.
- **`busy`** = state≠IDLE.
- **Mutual exclusion:** `mem_doe` and `memoe_n`=0 are never asserted together.

## Timing
- **Reset values:**
  - `addr`=0, `wdat`=0, `rlatch`=FF, `ovf`=0, state IDLE.
  - `romcs_n`=`memoe_n`=`memwe_n`=1, `mem_doe`=0, `busy`=0.
  - `zxid_oe` follows decode; it is combinational and not reset.
- **Reset mid-cycle:** all memory controls go inactive on the next clk edge, and the cycle is abandoned with no `addr` increment.
- **Strobe-to-action latency:** 3 clks from the pin edge (2 sync + 1 edge detect).
- **Write cycle:** WE_CYC+2 clks busy. Read cycle: RD_CYC+1 clks busy.
- **Host pacing:** the host needs ≥ busy length + 3 clks between DATA accesses. At default parameters this is 8 clks (333 ns), which is met by back-to-back Z80 OUTs.
- **Simultaneous events:** a write event and a read-end event cannot coincide (a single ZX strobe is active at a time). If both synced strobes assert together, write has priority and the read-end is dropped.

## Test plan
- **Reset:** assert `warmres_n`=0 for 2 clks → all memory controls 1, `mem_doe`=0, STATUS read returns 00, DATA read returns FF.
- **Address and write:** OUT B0←34, B1←12, B2←05, B3←A5 → one write cycle:
  - `mem_a`=51234, `mem_dout`=A5;
  - `memwe_n` low exactly 3 clks, framed by 1 clk of `romcs_n` low on each side;
  - afterwards ADDR0/1/2 read back 35, 12, 05.
- **Read prefetch:** `mem_din`=5A, addr=00010, IN B3 → returns FF; a read cycle follows at 00010 with `memoe_n` low 4 clks. Next IN B3 → 5A, and addr=00012 after its prefetch.
- **Overflow:** OUT B3 twice, 2 clks apart after sync → only one write cycle runs, STATUS=03 while busy. After completion STATUS reads 02 once, then 00.
- **Wrap:** addr=7FFFF, OUT B3←00 → write at 7FFFF, addr becomes 00000.
- **Reset mid-operation:** assert reset during W_PULSE → `memwe_n`=1 next clk, addr unchanged, `busy`=0.

Source files
------------

// File: rtl/zx_flash_port.sv
// ZX-bus I/O responder for the NeoGS flash programmer: five host ports mapped onto
// timed flash ROM read/write cycles (address regs, DATA, STATUS with overflow flag).
module zx_flash_port #(
  parameter logic [7:0] PORT_BASE = 8'hB0,
  parameter int         WE_CYC    = 3,
  parameter int         RD_CYC    = 4
) (
  input  logic        clk,
  input  logic        warmres_n,
  input  logic [7:0]  zxa,
  input  logic        zxiorq_n,
  input  logic        zxrd_n,
  input  logic        zxwr_n,
  input  logic [7:0]  zxid_in,
  output logic [7:0]  zxid_out,
  output logic        zxid_oe,
  output logic        zxblkiorq_n,
  output logic        zxbusin,
  output logic        zxbusena_n,
  output logic [18:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_doe,
  input  logic [7:0]  mem_din,
  output logic        romcs_n,
  output logic        memoe_n,
  output logic        memwe_n,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_PULSE, R_DONE} state_t;

  state_t      state_q;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  wdat_q, rlatch_q, cnt_q;
  logic        ovf_q, ovf_d;
  logic        romcs_q, memoe_q, memwe_q, doe_q;
  logic [2:0]  wr_sync_q, rd_sync_q, rd_off_q;

  logic [7:0]  off;
  logic        in_rng, sel, wr_raw, rd_raw;
  logic        wr_ev, wr_act, rd_rise, rd_end, idle;

  // Decode straight from the pins so the bus buffers turn around immediately.
  assign off    = zxa - PORT_BASE;
  assign in_rng = (off < 8'd5);
  assign sel    = in_rng & ~zxiorq_n;

  assign zxblkiorq_n = ~sel;
  assign zxbusena_n  = ~sel;
  assign zxbusin     = ~(sel & ~zxrd_n);
  assign zxid_oe     = sel & ~zxrd_n;

  always_comb begin
    zxid_out = 8'h00;
    case (off)
      8'd0:    zxid_out = addr_q[7:0];
      8'd1:    zxid_out = addr_q[15:8];
      8'd2:    zxid_out = {5'b0, addr_q[18:16]};
      8'd3:    zxid_out = rlatch_q;
      8'd4:    zxid_out = {6'b0, ovf_q, ~idle};
      default: zxid_out = 8'h00;
    endcase
  end

  assign wr_raw = ~zxiorq_n & ~zxwr_n & sel;
  assign rd_raw = ~zxiorq_n & ~zxrd_n & sel;

  assign wr_ev   = wr_sync_q[1] & ~wr_sync_q[2];
  assign wr_act  = wr_ev & in_rng;
  assign rd_rise = rd_sync_q[1] & ~rd_sync_q[2];
  // A read-end coinciding with a write event is dropped; the write wins.
  assign rd_end  = ~rd_sync_q[1] & rd_sync_q[2] & ~wr_ev;
  assign idle    = (state_q == IDLE);
  assign addr_d  = addr_q + 19'd1;

  always_ff @(posedge clk) begin
    if (!warmres_n) begin
      wr_sync_q <= '0;
      rd_sync_q <= '0;
      rd_off_q  <= 3'd7;
    end else begin
      wr_sync_q <= {wr_sync_q[1:0], wr_raw};
      rd_sync_q <= {rd_sync_q[1:0], rd_raw};
      // The host may drop the address before the synced read-end arrives.
      if (rd_rise) rd_off_q <= in_rng ? off[2:0] : 3'd7;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (rd_end && rd_off_q == 3'd4) ovf_d = 1'b0;
    if (!idle && wr_act && off < 8'd4) ovf_d = 1'b1;
    if (!idle && rd_end && rd_off_q == 3'd3) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!warmres_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdat_q   <= '0;
      rlatch_q <= 8'hFF;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      romcs_q  <= 1'b1;
      memoe_q  <= 1'b1;
      memwe_q  <= 1'b1;
      doe_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      case (state_q)
        IDLE: begin
          if (wr_act) begin
            case (off[2:0])
              3'd0: addr_q[7:0]   <= zxid_in;
              3'd1: addr_q[15:8]  <= zxid_in;
              3'd2: addr_q[18:16] <= zxid_in[2:0];
              3'd3: begin
                wdat_q  <= zxid_in;
                romcs_q <= 1'b0;
                doe_q   <= 1'b1;
                state_q <= W_SETUP;
              end
              default: ;
            endcase
          end else if (rd_end && rd_off_q == 3'd3) begin
            romcs_q <= 1'b0;
            memoe_q <= 1'b0;
            cnt_q   <= 8'(RD_CYC - 1);
            state_q <= R_PULSE;
          end
        end
        W_SETUP: begin
          memwe_q <= 1'b0;
          cnt_q   <= 8'(WE_CYC - 1);
          state_q <= W_PULSE;
        end
        W_PULSE: begin
          if (cnt_q == 8'd0) begin
            memwe_q <= 1'b1;
            state_q <= W_HOLD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        W_HOLD: begin
          romcs_q <= 1'b1;
          doe_q   <= 1'b0;
          addr_q  <= addr_d;
          state_q <= IDLE;
        end
        R_PULSE: begin
          if (cnt_q == 8'd0) begin
            rlatch_q <= mem_din;
            romcs_q  <= 1'b1;
            memoe_q  <= 1'b1;
            state_q  <= R_DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        R_DONE: begin
          addr_q  <= addr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_a    = addr_q;
  assign mem_dout = wdat_q;
  assign mem_doe  = doe_q;
  assign romcs_n  = romcs_q;
  assign memoe_n  = memoe_q;
  assign memwe_n  = memwe_q;
  assign busy     = ~idle;

endmodule

// File: tb/tb_zx_flash_port.sv
// Scoreboard bench for zx_flash_port: a port-level model predicts IN data and flash
// cycles; two monitors compare host reads and memory-side cycles independently.
`timescale 1ns/1ps
module tb_zx_flash_port;
  localparam logic [7:0] BASE = 8'hB0;
  localparam int WE_CYC = 3;
  localparam int RD_CYC = 4;

  typedef struct {
    logic        wr;
    logic [18:0] a;
    logic [7:0]  d;
    logic        abort;
  } cyc_t;

  logic        clk = 1'b0;
  logic        warmres_n;
  logic [7:0]  zxa, zxid_in, zxid_out, mem_dout, mem_din;
  logic        zxiorq_n, zxrd_n, zxwr_n;
  logic        zxid_oe, zxblkiorq_n, zxbusin, zxbusena_n;
  logic [18:0] mem_a;
  logic        mem_doe, romcs_n, memoe_n, memwe_n, busy;

  logic        fixed_en;
  logic [7:0]  fixed_din;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_rd[$];
  cyc_t       exp_cyc[$];

  logic [18:0] m_addr;
  logic [7:0]  m_rlatch;
  logic        m_ovf;

  function automatic logic [7:0] fhash(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b0} ^ 8'hC3;
  endfunction

  function automatic logic [7:0] din_of(input logic [18:0] a);
    return fixed_en ? fixed_din : fhash(a);
  endfunction

  assign mem_din = din_of(mem_a);

  always #5 clk = ~clk;

  zx_flash_port #(.PORT_BASE(BASE), .WE_CYC(WE_CYC), .RD_CYC(RD_CYC)) dut (
    .clk(clk), .warmres_n(warmres_n), .zxa(zxa),
    .zxiorq_n(zxiorq_n), .zxrd_n(zxrd_n), .zxwr_n(zxwr_n),
    .zxid_in(zxid_in), .zxid_out(zxid_out), .zxid_oe(zxid_oe),
    .zxblkiorq_n(zxblkiorq_n), .zxbusin(zxbusin), .zxbusena_n(zxbusena_n),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_doe(mem_doe), .mem_din(mem_din),
    .romcs_n(romcs_n), .memoe_n(memoe_n), .memwe_n(memwe_n), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_rlatch = 8'hFF; m_ovf = 1'b0;
  endtask

  task automatic zx_cycle(input logic [7:0] a, input logic [7:0] d, input logic is_wr, input int gap);
    @(posedge clk); #1;
    zxa = a; zxid_in = d; zxiorq_n = 1'b0;
    if (is_wr) zxwr_n = 1'b0; else zxrd_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 zxiorq_n = 1'b1; zxwr_n = 1'b1; zxrd_n = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic do_out(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] o;
    o = a - BASE;
    case (o)
      8'd0: m_addr[7:0]   = d;
      8'd1: m_addr[15:8]  = d;
      8'd2: m_addr[18:16] = d[2:0];
      8'd3: begin exp_cyc.push_back('{1'b1, m_addr, d, 1'b0}); m_addr = m_addr + 19'd1; end
      default: ;
    endcase
    zx_cycle(a, d, 1'b1, 12);
  endtask

  task automatic do_in(input logic [7:0] a);
    logic [7:0] o;
    o = a - BASE;
    case (o)
      8'd0: exp_rd.push_back(m_addr[7:0]);
      8'd1: exp_rd.push_back(m_addr[15:8]);
      8'd2: exp_rd.push_back({5'b0, m_addr[18:16]});
      8'd3: begin
        exp_rd.push_back(m_rlatch);
        exp_cyc.push_back('{1'b0, m_addr, 8'h00, 1'b0});
        m_rlatch = din_of(m_addr);
        m_addr = m_addr + 19'd1;
      end
      8'd4: begin exp_rd.push_back({6'b0, m_ovf, 1'b0}); m_ovf = 1'b0; end
      default: ;
    endcase
    zx_cycle(a, 8'h00, 1'b0, 14);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 warmres_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 warmres_n = 1'b1;
    model_reset();
  endtask

  // Host-read monitor: one comparison per IN cycle seen on the bus.
  initial begin
    logic oe_prev;
    oe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (zxid_oe && !oe_prev) begin
        if (exp_rd.size() == 0) check("rd_unexpected", {24'b0, zxa}, 32'hFFFF);
        else begin
          check("rd_data", zxid_out, exp_rd.pop_front());
          check("rd_busin", zxbusin, 1'b0);
          check("rd_bufena", zxbusena_n, 1'b0);
        end
      end
      oe_prev = zxid_oe;
    end
  end

  // Flash-side monitor: measures each romcs_n-low window against the expected cycle.
  initial begin
    cyc_t c;
    int ncs, nwe, noe;
    logic fwe, lwe, xbad;
    logic [18:0] seen_a;
    logic [7:0]  seen_d;
    forever begin
      @(negedge clk);
      if (romcs_n === 1'b0) begin
        if (exp_cyc.size() == 0) begin
          check("cyc_unexpected", {13'b0, mem_a}, 32'hFFFFFFFF);
          c = '{1'b0, mem_a, 8'h00, 1'b1};
        end else c = exp_cyc.pop_front();
        ncs = 0; nwe = 0; noe = 0; fwe = 1'b0; lwe = 1'b0; xbad = 1'b0;
        seen_a = c.a; seen_d = c.d;
        while (romcs_n === 1'b0 && ncs < 64) begin
          ncs++;
          if (!memwe_n) nwe++;
          if (!memoe_n) noe++;
          if (ncs == 1) fwe = memwe_n;
          lwe = memwe_n;
          if (mem_doe && !memoe_n) xbad = 1'b1;
          if (mem_a !== c.a) seen_a = mem_a;
          if (!memwe_n && mem_dout !== c.d) seen_d = mem_dout;
          @(negedge clk);
        end
        check("cyc_addr", seen_a, c.a);
        if (!c.abort) begin
          check("cyc_we_len", nwe, c.wr ? WE_CYC : 0);
          check("cyc_oe_len", noe, c.wr ? 0 : RD_CYC);
          check("cyc_cs_len", ncs, c.wr ? WE_CYC + 2 : RD_CYC);
          check("doe_oe_excl", xbad, 1'b0);
          if (c.wr) begin
            check("wr_data", seen_d, c.d);
            check("we_framed", {fwe, lwe}, 2'b11);
          end
        end
      end
    end
  end

  initial begin
    #300us;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    warmres_n = 1'b0; zxa = 8'h00; zxid_in = 8'h00;
    zxiorq_n = 1'b1; zxrd_n = 1'b1; zxwr_n = 1'b1;
    fixed_en = 1'b0; fixed_din = 8'h00;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_romcs", romcs_n, 1'b1);
    check("rst_memoe", memoe_n, 1'b1);
    check("rst_memwe", memwe_n, 1'b1);
    check("rst_doe", mem_doe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", mem_a, 19'h0);
    @(posedge clk); #1 warmres_n = 1'b1;
    do_in(BASE + 8'd4);
    do_in(BASE + 8'd3);

    // Address setup and one write
    do_out(BASE + 8'd0, 8'h34);
    do_out(BASE + 8'd1, 8'h12);
    do_out(BASE + 8'd2, 8'h05);
    do_out(BASE + 8'd3, 8'hA5);
    do_in(BASE + 8'd0); do_in(BASE + 8'd1); do_in(BASE + 8'd2);

    // Read prefetch from a fresh reset
    pulse_reset();
    fixed_en = 1'b1; fixed_din = 8'h5A;
    do_out(BASE + 8'd0, 8'h10);
    do_in(BASE + 8'd3);
    do_in(BASE + 8'd3);
    do_in(BASE + 8'd0);
    fixed_en = 1'b0;

    // Overflow: second DATA write lands while the first cycle is running
    exp_cyc.push_back('{1'b1, m_addr, 8'h11, 1'b0});
    m_addr = m_addr + 19'd1;
    m_ovf = 1'b1;
    @(posedge clk); #1 zxa = BASE + 8'd3; zxid_in = 8'h11; zxiorq_n = 1'b0; zxwr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 zxiorq_n = 1'b1; zxwr_n = 1'b1;
    @(posedge clk); #1 zxid_in = 8'h22; zxiorq_n = 1'b0; zxwr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 zxiorq_n = 1'b1; zxwr_n = 1'b1;
    @(posedge clk); #1 zxa = BASE + 8'd4;
    @(negedge clk);
    check("status_busy_ovf", zxid_out, 8'h03);
    repeat (20) @(posedge clk);
    do_in(BASE + 8'd4);
    do_in(BASE + 8'd4);
    do_in(BASE + 8'd0);

    // Address wrap
    do_out(BASE + 8'd0, 8'hFF);
    do_out(BASE + 8'd1, 8'hFF);
    do_out(BASE + 8'd2, 8'h07);
    do_out(BASE + 8'd3, 8'h00);
    do_in(BASE + 8'd0); do_in(BASE + 8'd1); do_in(BASE + 8'd2);

    // Randomised traffic, including addresses outside the port window
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [7:0] na;
      op = $urandom_range(0, 7);
      case (op)
        0, 1, 2: do_out(BASE + 8'(op), 8'($urandom_range(0, 255)));
        3: do_out(BASE + 8'd3, 8'($urandom_range(0, 255)));
        4: do_in(BASE + 8'd3);
        5: do_in(BASE + 8'd4);
        6: do_in(BASE + 8'($urandom_range(0, 2)));
        default: begin
          na = ($urandom_range(0, 1) == 1) ? 8'(8'hB5 + $urandom_range(0, 32))
                                           : 8'($urandom_range(0, 8'hAF));
          if ($urandom_range(0, 1) == 1) do_out(na, 8'($urandom_range(0, 255)));
          else do_in(na);
        end
      endcase
    end

    // Reset during the write pulse abandons the cycle
    do_out(BASE + 8'd0, 8'h00);
    do_out(BASE + 8'd1, 8'h00);
    do_out(BASE + 8'd2, 8'h00);
    exp_cyc.push_back('{1'b1, 19'h0, 8'h77, 1'b1});
    @(posedge clk); #1 zxa = BASE + 8'd3; zxid_in = 8'h77; zxiorq_n = 1'b0; zxwr_n = 1'b0;
    begin
      int k;
      k = 0;
      while (memwe_n !== 1'b0 && k < 30) begin @(negedge clk); k++; end
      check("midrst_we_seen", memwe_n, 1'b0);
    end
    @(posedge clk); #1 zxiorq_n = 1'b1; zxwr_n = 1'b1; warmres_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_memwe", memwe_n, 1'b1);
    check("midrst_romcs", romcs_n, 1'b1);
    check("midrst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 warmres_n = 1'b1;
    model_reset();
    do_in(BASE + 8'd0); do_in(BASE + 8'd1); do_in(BASE + 8'd2);

    repeat (10) @(posedge clk);
    check("rd_left", exp_rd.size(), 0);
    check("cyc_left", exp_cyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
